// File: rtl/game_pkg.sv
// Shared encodings, thresholds and helpers for the whack-a-mole round/level controller.
package game_pkg;

   localparam int unsigned SPEED_W       = 28;
   localparam int unsigned NUM_LEVELS    = 4;
   localparam int unsigned LEVEL_W       = 2;
   localparam int unsigned TIME_W        = 8;
   localparam int unsigned SCORE_W       = 8;
   localparam int unsigned BONUS_SECONDS = 10;

   localparam logic [SCORE_W-1:0] LVL1_SCORE = SCORE_W'(8);
   localparam logic [SCORE_W-1:0] LVL2_SCORE = SCORE_W'(16);
   localparam logic [SCORE_W-1:0] LVL3_SCORE = SCORE_W'(32);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;
   localparam logic [1:0] ST_OVER = 2'd3;

   // Level the current score entitles the player to.
   function automatic logic [LEVEL_W-1:0] level_target(input logic [SCORE_W-1:0] score);
      if (score >= LVL3_SCORE)      return LEVEL_W'(3);
      else if (score >= LVL2_SCORE) return LEVEL_W'(2);
      else if (score >= LVL1_SCORE) return LEVEL_W'(1);
      else                          return LEVEL_W'(0);
   endfunction

   function automatic logic [SPEED_W-1:0] level_speed(input logic [LEVEL_W-1:0] lvl,
                                                      input logic [SPEED_W-1:0] base);
      case (lvl)
         LEVEL_W'(0): return base;
         LEVEL_W'(1): return base - (base >> 2);
         LEVEL_W'(2): return base >> 1;
         default:     return base >> 2;
      endcase
   endfunction

   // Adds the level-up bonus, clamping at the largest representable time.
   function automatic logic [TIME_W-1:0] add_bonus(input logic [TIME_W-1:0] t);
      logic [TIME_W:0] sum;
      sum = {1'b0, t} + (TIME_W+1)'(BONUS_SECONDS);
      return sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
   endfunction

endpackage

// File: rtl/sec_tick.sv
// Seconds prescaler: counts enabled cycles 0..CLK_HZ-1 and flags the last one.
module sec_tick #(
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic tick_c
);

   localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_c = enable_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)       cnt_d = '0;
      else if (enable_i) cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/level_controller.sv
// Round timer and difficulty controller. Define LEVEL_BONUS_TIME_EN to grant
// BONUS_SECONDS extra round time on every level-up.
module level_controller
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50000000,
   parameter int unsigned ROUND_SECONDS = 60,
   parameter int unsigned BASE_SPEED    = 50000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [SCORE_W-1:0] score,
   output logic               game,
   output logic [SPEED_W-1:0] speed,
   output logic [LEVEL_W-1:0] level,
   output logic [TIME_W-1:0]  time_left,
   output logic               game_over,
   output logic               level_up
);

   localparam logic [SPEED_W-1:0] BASE_S  = SPEED_W'(BASE_SPEED);
   localparam logic [TIME_W-1:0]  ROUND_T = TIME_W'(ROUND_SECONDS);

   logic [1:0]         state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               level_up_q, level_up_d;
   logic [TIME_W-1:0]  time_q, time_d, time_adj;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               game_q, game_d;
   logic               game_over_q, game_over_d;
   logic               tick_c;

   sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
      .clock_i  (clock),
      .reset_i  (reset),
      .clear_i  (state_q == ST_ARM),
      .enable_i (state_q == ST_PLAY),
      .tick_c   (tick_c)
   );

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      level_up_d = 1'b0;
      time_d     = time_q;
      time_adj   = time_q;
      // Speed follows the registered level, so it trails a level change by one cycle.
      speed_d    = level_speed(level_q, BASE_S);
      case (state_q)
         ST_IDLE: if (start) state_d = ST_ARM;
         ST_ARM: begin
            time_d  = ROUND_T;
            level_d = '0;
            speed_d = BASE_S;
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (level_target(score) > level_q) begin
               level_d    = level_q + LEVEL_W'(1);
               level_up_d = 1'b1;
            end
`ifdef LEVEL_BONUS_TIME_EN
            if (level_up_d) time_adj = add_bonus(time_q);
`endif
            time_d = time_adj;
            if (tick_c) begin
               time_d = time_adj - TIME_W'(1);
               if (time_d == '0) state_d = ST_OVER;
            end
         end
         ST_OVER: begin
            time_d = '0;
            if (start) state_d = ST_ARM;
         end
         default: state_d = ST_IDLE;
      endcase
      game_d      = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         level_q     <= '0;
         level_up_q  <= 1'b0;
         time_q      <= '0;
         speed_q     <= BASE_S;
         game_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         level_up_q  <= level_up_d;
         time_q      <= time_d;
         speed_q     <= speed_d;
         game_q      <= game_d;
         game_over_q <= game_over_d;
      end
   end

   assign game      = game_q;
   assign speed     = speed_q;
   assign level     = level_q;
   assign time_left = time_q;
   assign game_over = game_over_q;
   assign level_up  = level_up_q;

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: vector table, corner-case sequences, random vs. reference model.
module tb_level_controller;

   localparam int unsigned CLK_HZ = 4;
   localparam int unsigned ROUND  = 3;
   localparam int unsigned BASE   = 64;
`ifdef LEVEL_BONUS_TIME_EN
   localparam int BONUS_EN = 1;
`else
   localparam int BONUS_EN = 0;
`endif

   logic        clock = 1'b0;
   logic        reset, start;
   logic [7:0]  score;
   logic        game, game_over, level_up;
   logic [27:0] speed;
   logic [1:0]  level;
   logic [7:0]  time_left;

   level_controller #(.CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND), .BASE_SPEED(BASE)) dut (
      .clock(clock), .reset(reset), .start(start), .score(score),
      .game(game), .speed(speed), .level(level), .time_left(time_left),
      .game_over(game_over), .level_up(level_up)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        start;
      logic [7:0]  score;
      logic        game, over;
      logic [1:0]  level;
      logic        up;
      logic [7:0]  tl;
      logic [27:0] spd;
   } vec_t;

   vec_t tbl[18];
   int n_vec = 0;
   int n_err = 0;

   // Reference model state (phase: 0 idle, 1 arm, 2 play, 3 over)
   int m_phase, m_cnt, m_tl, m_lvl, m_up, m_spd;

   function automatic vec_t mk(logic st, logic [7:0] sc, logic g, logic o, logic [1:0] l,
                               logic u, logic [7:0] t, logic [27:0] s);
      vec_t v;
      v.start = st; v.score = sc; v.game = g; v.over = o; v.level = l; v.up = u; v.tl = t; v.spd = s;
      return v;
   endfunction

   function automatic logic [40:0] dut_vec();
      return {game, game_over, level, level_up, time_left, speed};
   endfunction

   task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got game=%0b over=%0b level=%0d up=%0b time=%0d speed=%0d; want game=%0b over=%0b level=%0d up=%0b time=%0d speed=%0d",
                  name, $time, act[40], act[39], act[38:37], act[36], act[35:28], act[27:0],
                  exp[40], exp[39], exp[38:37], exp[36], exp[35:28], exp[27:0]);
      end
   endtask

   task automatic checkf(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic [7:0] sc);
      start = st; score = sc;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; score = 8'd0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic begin_round();
      step(1'b1, 8'd0);
      step(1'b0, 8'd0);
   endtask

   function automatic int spd_of(int l);
      case (l)
         0: return BASE;
         1: return BASE - BASE / 4;
         2: return BASE / 2;
         default: return BASE / 4;
      endcase
   endfunction

   // Behavioural round/level model advanced once per clock edge.
   task automatic model_step(input logic rst, input logic st, input logic [7:0] sc);
      int tgt;
      bit tick;
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_tl = 0; m_lvl = 0; m_up = 0; m_spd = BASE;
         return;
      end
      case (m_phase)
         0: begin m_up = 0; m_spd = spd_of(m_lvl); if (st) m_phase = 1; end
         1: begin m_tl = ROUND; m_lvl = 0; m_cnt = 0; m_spd = BASE; m_up = 0; m_phase = 2; end
         2: begin
            tick  = (m_cnt == CLK_HZ - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            tgt   = (sc >= 32) ? 3 : (sc >= 16) ? 2 : (sc >= 8) ? 1 : 0;
            m_spd = spd_of(m_lvl);
            m_up  = (tgt > m_lvl) ? 1 : 0;
            if (m_up == 1) begin
               m_lvl++;
               if (BONUS_EN == 1) m_tl = (m_tl + 10 > 255) ? 255 : m_tl + 10;
            end
            if (tick) begin
               m_tl--;
               if (m_tl == 0) m_phase = 3;
            end
         end
         default: begin m_up = 0; m_spd = spd_of(m_lvl); m_tl = 0; if (st) m_phase = 1; end
      endcase
   endtask

   function automatic logic [40:0] model_vec();
      return {(m_phase == 2), (m_phase == 3), 2'(m_lvl), 1'(m_up), 8'(m_tl), 28'(m_spd)};
   endfunction

   initial begin
      logic [7:0] cur_score;
      logic       r_rst, r_st;
      int         r, guard;

      // Round from IDLE through OVER and a restart.
      tbl[0]  = mk(1'b0, 8'd50, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64);
      tbl[1]  = mk(1'b1, 8'd0,  1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64);
      for (int i = 2; i <= 13; i++)
         tbl[i] = mk(1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 1'b0, 8'(3 - (i - 2) / 4), 28'd64);
      tbl[14] = mk(1'b0, 8'd0,  1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 28'd64);
      tbl[15] = mk(1'b0, 8'd40, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 28'd64);
      tbl[16] = mk(1'b1, 8'd0,  1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64);
      tbl[17] = mk(1'b0, 8'd40, 1'b1, 1'b0, 2'd0, 1'b0, 8'd3, 28'd64);

      reset = 1'b1; start = 1'b0; score = 8'd0;
      @(posedge clock); #1;
      check("reset_state", dut_vec(), {1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64});
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].start, tbl[i].score);
         check($sformatf("table[%0d]", i), dut_vec(),
               {tbl[i].game, tbl[i].over, tbl[i].level, tbl[i].up, tbl[i].tl, tbl[i].spd});
      end

      // Stepped score: one level per threshold, speed lags a cycle, no decrease.
      do_reset(); begin_round();
      step(1'b0, 8'd8);  checkf("lvl1", level, 1); checkf("lvl1_up", level_up, 1); checkf("lvl1_spd_lag", speed, 64);
      step(1'b0, 8'd8);  checkf("lvl1_hold", level, 1); checkf("lvl1_up_off", level_up, 0); checkf("spd48", speed, 48);
      step(1'b0, 8'd16); checkf("lvl2", level, 2); checkf("lvl2_up", level_up, 1);
      step(1'b0, 8'd32); checkf("lvl3", level, 3); checkf("lvl3_up", level_up, 1); checkf("spd32", speed, 32);
      step(1'b0, 8'd0);  checkf("lvl3_drop", level, 3); checkf("spd16", speed, 16); checkf("lvl3_up_off", level_up, 0);
      repeat (3) step(1'b0, 8'd0);
      checkf("lvl3_keep", level, 3);

      // Run out the clock, then restart from OVER at level 0.
      guard = 0;
      while (game_over !== 1'b1 && guard < 300) begin step(1'b0, 8'd0); guard++; end
      checkf("reach_over", game_over, 1);
      checkf("over_level_held", level, 3);
      begin_round();
      checkf("restart_level", level, 0); checkf("restart_speed", speed, 64);
      checkf("restart_time", time_left, 3); checkf("restart_game", game, 1);

      // Big score jump still climbs one level per cycle; start ignored in PLAY.
      step(1'b1, 8'd40); checkf("jump_l1", level, 1); checkf("start_in_play", game, 1);
      step(1'b0, 8'd40); checkf("jump_l2", level, 2);
      step(1'b0, 8'd40); checkf("jump_l3", level, 3);

      // Asynchronous reset mid-round.
      reset = 1'b1; #2;
      check("async_reset", dut_vec(), {1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64});
      @(posedge clock); #1; reset = 1'b0;
      repeat (3) step(1'b0, 8'd40);
      check("idle_after_reset", dut_vec(), {1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 28'd64});

      // Start during ARM is ignored.
      step(1'b1, 8'd0); step(1'b1, 8'd0);
      checkf("arm_start_game", game, 1); checkf("arm_start_time", time_left, 3);

      // Level-up on the final tick.
      do_reset(); begin_round();
      repeat (11) step(1'b0, 8'd0);
      checkf("last_second", time_left, 1);
      step(1'b0, 8'd8);
      checkf("last_tick_level", level, 1);
`ifdef LEVEL_BONUS_TIME_EN
      checkf("bonus_time", time_left, 10); checkf("bonus_game", game, 1);
`else
      checkf("nobonus_over", game_over, 1); checkf("nobonus_time", time_left, 0);
`endif

      // Randomized run against the reference model.
      cur_score = 8'd0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         r_rst = (i == 0) || (r < 2);
         r_st  = (r >= 2) && (r < 12);
         if ($urandom_range(0, 11) == 0) cur_score = 8'($urandom_range(0, 63));
         reset = r_rst; start = r_st; score = cur_score;
         @(posedge clock); #1;
         model_step(r_rst, r_st, cur_score);
         check($sformatf("random[%0d]", i), dut_vec(), model_vec());
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/level_controller.md
LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clock cycles per one-second tick.
REQ-002 Parameter ROUND_SECONDS, default 60: round length in seconds (1..255).
REQ-003 Parameter BASE_SPEED, default 50000000: level-0 mole period in clocks, 28 bits.
REQ-004 Ports: clock (input, 1): sole clock, rising edge; reset (input, 1): asynchronous, active-high.
REQ-005 start (input, 1): one-cycle pulse requesting a new round.
REQ-006 score (input, 8): current player score.
REQ-007 game (output, 1): high only while a round is in play; drives player and display enable.
REQ-008 speed (output, 28): mole period for the display controller.
REQ-009 level (output, 2): current difficulty level, 0..3.
REQ-010 time_left (output, 8): remaining round seconds.
REQ-011 game_over (output, 1): high in OVER state.
REQ-012 level_up (output, 1): one-cycle pulse on each level increment.

Function
REQ-013 FSM states: IDLE, ARM, PLAY, OVER; all outputs registered.
REQ-014 IDLE: start=1 -> ARM; otherwise stay.
REQ-015 ARM, exactly one cycle, game=0: time_left<=ROUND_SECONDS, level<=0, prescaler<=0; next state PLAY.
REQ-016 PLAY: game=1; prescaler counts 0..CLK_HZ-1; tick asserted in the cycle count==CLK_HZ-1, then wraps to 0.
REQ-017 PLAY tick: time_left decrements by 1; if the result is 0 -> OVER in the same edge.
REQ-018 OVER: game=0, game_over=1, time_left=0, level and speed held; start=1 -> ARM.
REQ-019 start is ignored in ARM and PLAY.
REQ-020 Level thresholds on score: >=8 -> 1, >=16 -> 2, >=32 -> 3; evaluated each PLAY cycle; level increments by at most 1 per cycle.
REQ-021 Level never decreases within a round, even if score drops.
REQ-022 level_up pulses for the cycle in which level becomes its new value.
REQ-023 speed = BASE_SPEED, BASE_SPEED - (BASE_SPEED>>2), BASE_SPEED>>1, BASE_SPEED>>2 for levels 0..3; updated one cycle after level changes.
REQ-024 Level/speed evaluation occurs only in PLAY; score changes in IDLE/ARM/OVER have no effect.

Reset
REQ-025 reset=1 forces IDLE asynchronously: game=0, game_over=0, level=0, level_up=0, time_left=0, speed=BASE_SPEED, prescaler=0.
REQ-026 Reset mid-PLAY aborts the round; after release, only start begins a new round.

Configuration
REQ-027 LEVEL_BONUS_TIME_EN defined: each level-up adds 10 to time_left, saturating at 255.
REQ-028 Same-cycle bonus and tick: next time_left = sat255(time_left+10) - 1; OVER only if the result is 0.
REQ-029 LEVEL_BONUS_TIME_EN undefined: no bonus logic; time_left changes only by ARM load and tick.

Structure
REQ-030 Shared package game_pkg holds state encoding, level thresholds (8/16/32), NUM_LEVELS=4, SPEED_W=28, BONUS_SECONDS=10.
REQ-031 One sub-module sec_tick: prescaler with clear and enable, single-cycle tick output.

Verification (CLK_HZ=4, ROUND_SECONDS=3, BASE_SPEED=64)
REQ-032 Reset, then start pulse -> ARM one cycle with game=0, then game=1, time_left=3, speed=64.
REQ-033 PLAY, score=0 -> time_left 3,2,1 at 4-cycle intervals, then game=0, game_over=1 after 12 PLAY cycles.
REQ-034 Score stepped 0->8->16->32 -> level 1,2,3, one level_up pulse each, speed 48,32,16; score then 0 -> level stays 3.
REQ-035 LEVEL_BONUS_TIME_EN, score 0->8 on the same cycle as the tick with time_left=1 -> time_left=10, stays PLAY; macro off -> OVER.
REQ-036 reset asserted mid-PLAY -> immediate IDLE, game=0, time_left=0; start pulse during PLAY -> no change; start in OVER -> new round with level=0.
